axis_seq_checker: RTL and testbench

AXI-Stream sink that sits directly downstream of the dummy counter source in the PS/PL stream CDC/timing demo. It consumes a stream of incrementing words, applies a programmable, deterministic backpressure pattern on `s_axis_tready`, and verifies that every accepted beat equals the previous accepted beat plus one (modulo 2^TDATA_BITS). Beat and error counters plus first-error capture are exported for ILA/AXI-Lite readback to prove lossless transfer across the stage.

---
 rtl/axis_seq_checker.sv | 117 +++++++++++
 tb/tb_axis_seq_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_seq_checker.sv
// Purpose: AXI-Stream sink that throttles tready and checks that accepted beats increment by one.
// Latency: stats, capture and err_pulse are updated at the handshake edge and visible 1 cycle later.
// Backpressure: tready is registered and driven by a programmable N-of-P phase pattern, gated by cfg_enable.
module axis_seq_checker #(
  parameter int TDATA_BITS = 32,
  parameter int CNT_BITS   = 32,
  parameter int PH_BITS    = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [TDATA_BITS-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  cfg_enable,
  input  logic [PH_BITS-1:0]    cfg_ready_period,
  input  logic [PH_BITS-1:0]    cfg_ready_on,
  input  logic                  clear,
  output logic [CNT_BITS-1:0]   stat_beats,
  output logic [CNT_BITS-1:0]   stat_errors,
  output logic                  stat_locked,
  output logic                  stat_err_sticky,
  output logic [TDATA_BITS-1:0] stat_first_err_exp,
  output logic [TDATA_BITS-1:0] stat_first_err_got,
  output logic                  err_pulse
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [PH_BITS-1:0]    PH_ONE  = PH_BITS'(1);
  localparam logic [CNT_BITS-1:0]   CNT_ONE = CNT_BITS'(1);
  localparam logic [TDATA_BITS-1:0] DAT_ONE = TDATA_BITS'(1);

  state_t                  state;
  logic [PH_BITS-1:0]      ph;
  logic [PH_BITS-1:0]      ph_next;
  logic [TDATA_BITS-1:0]   expected;
  logic                    hs;

  assign hs          = s_axis_tvalid && s_axis_tready;
  assign stat_locked = (state == ST_LOCKED);

  // Next throttle phase: frozen when disabled, wraps at P-1 (or if P shrank below ph).
  always_comb begin
    ph_next = ph;
    if (clear) begin
      ph_next = '0;
    end else if (cfg_enable) begin
      if ((cfg_ready_period == '0) || (ph >= (cfg_ready_period - PH_ONE))) begin
        ph_next = '0;
      end else begin
        ph_next = ph + PH_ONE;
      end
    end
  end

  // Phase counter and registered tready computed from the phase the counter is moving to.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ph            <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      ph            <= ph_next;
      s_axis_tready <= cfg_enable && ((cfg_ready_period == '0) || (ph_next < cfg_ready_on));
    end
  end

  // Lock/check FSM with saturating statistics and first-mismatch capture; clear beats a handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state              <= ST_UNLOCKED;
      expected           <= '0;
      stat_beats         <= '0;
      stat_errors        <= '0;
      stat_err_sticky    <= 1'b0;
      stat_first_err_exp <= '0;
      stat_first_err_got <= '0;
      err_pulse          <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        state              <= ST_UNLOCKED;
        expected           <= '0;
        stat_beats         <= '0;
        stat_errors        <= '0;
        stat_err_sticky    <= 1'b0;
        stat_first_err_exp <= '0;
        stat_first_err_got <= '0;
      end else if (hs) begin
        if (stat_beats != '1) begin
          stat_beats <= stat_beats + CNT_ONE;
        end
        if (state == ST_UNLOCKED) begin
          expected <= s_axis_tdata + DAT_ONE;
          state    <= ST_LOCKED;
        end else if (s_axis_tdata == expected) begin
          expected <= expected + DAT_ONE;
        end else begin
          // Mismatch: count it, flag it, and resync to the received value.
          err_pulse <= 1'b1;
          expected  <= s_axis_tdata + DAT_ONE;
          if (stat_errors != '1) begin
            stat_errors <= stat_errors + CNT_ONE;
          end
          if (!stat_err_sticky) begin
            stat_err_sticky    <= 1'b1;
            stat_first_err_exp <= expected;
            stat_first_err_got <= s_axis_tdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Bench for axis_seq_checker: directed stream scenarios with a reference checker model.
// err_pulse expectations are queued when each beat is driven and compared one edge later.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_axis_seq_checker;

  localparam int TDW = 32;
  localparam int CW  = 32;
  localparam int PW  = 8;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [TDW-1:0] s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           cfg_enable = 1'b0;
  logic [PW-1:0]  cfg_ready_period = '0;
  logic [PW-1:0]  cfg_ready_on = '0;
  logic           clear = 1'b0;
  logic [CW-1:0]  stat_beats;
  logic [CW-1:0]  stat_errors;
  logic           stat_locked;
  logic           stat_err_sticky;
  logic [TDW-1:0] stat_first_err_exp;
  logic [TDW-1:0] stat_first_err_got;
  logic           err_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  logic pulse_q[$];

  // Reference checker state
  logic           m_locked;
  logic [TDW-1:0] m_exp;
  logic [CW-1:0]  m_beats;
  logic [CW-1:0]  m_errs;
  logic           m_sticky;
  logic [TDW-1:0] m_fexp;
  logic [TDW-1:0] m_fgot;

  axis_seq_checker #(.TDATA_BITS(TDW), .CNT_BITS(CW), .PH_BITS(PW)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .cfg_enable         (cfg_enable),
    .cfg_ready_period   (cfg_ready_period),
    .cfg_ready_on       (cfg_ready_on),
    .clear              (clear),
    .stat_beats         (stat_beats),
    .stat_errors        (stat_errors),
    .stat_locked        (stat_locked),
    .stat_err_sticky    (stat_err_sticky),
    .stat_first_err_exp (stat_first_err_exp),
    .stat_first_err_got (stat_first_err_got),
    .err_pulse          (err_pulse)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_locked = 1'b0;
    m_exp    = '0;
    m_beats  = '0;
    m_errs   = '0;
    m_sticky = 1'b0;
    m_fexp   = '0;
    m_fgot   = '0;
  endfunction

  task automatic check_stats(input string pfx);
    chk({pfx, "_beats"},  64'(stat_beats),         64'(m_beats));
    chk({pfx, "_errors"}, 64'(stat_errors),        64'(m_errs));
    chk({pfx, "_locked"}, 64'(stat_locked),        64'(m_locked));
    chk({pfx, "_sticky"}, 64'(stat_err_sticky),    64'(m_sticky));
    chk({pfx, "_fexp"},   64'(stat_first_err_exp), 64'(m_fexp));
    chk({pfx, "_fgot"},   64'(stat_first_err_got), 64'(m_fgot));
  endtask

  // One clock: predict this edge's outcome, advance, then score err_pulse.
  task automatic cycle(output logic hs);
    logic e;
    logic exp_e;
    hs = s_axis_tvalid && s_axis_tready;
    e  = 1'b0;
    if (clear) begin
      model_clear();
    end else if (hs) begin
      m_beats = m_beats + 1;
      if (!m_locked) begin
        m_locked = 1'b1;
        m_exp    = s_axis_tdata + 1;
      end else if (s_axis_tdata != m_exp) begin
        e      = 1'b1;
        m_errs = m_errs + 1;
        if (!m_sticky) begin
          m_sticky = 1'b1;
          m_fexp   = m_exp;
          m_fgot   = s_axis_tdata;
        end
        m_exp = s_axis_tdata + 1;
      end else begin
        m_exp = m_exp + 1;
      end
    end
    pulse_q.push_back(e);
    @(posedge aclk);
    #1;
    exp_e = pulse_q.pop_front();
    chk("err_pulse", 64'(err_pulse), 64'(exp_e));
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [TDW-1:0] d);
    logic hs;
    hs = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 20 && !hs; k++) cycle(hs);
    chk("send_accepted", 64'(hs), 64'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_clear();
    logic hs;
    s_axis_tvalid = 1'b0;
    clear = 1'b1;
    cycle(hs);
    clear = 1'b0;
    chk("clear_beats",  64'(stat_beats),  64'(0));
    chk("clear_locked", 64'(stat_locked), 64'(0));
  endtask

  initial begin
    logic           hs;
    logic [TDW-1:0] src;
    int             rdy_cnt;
    int             consec;
    logic           prev_rdy;
    logic [TDW-1:0] skip_seq [7];
    logic [TDW-1:0] wrap_seq [4];

    model_clear();
    skip_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7};
    wrap_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    // Reset values while areset is held
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready",  64'(s_axis_tready), 64'(0));
    chk("rst_pulse",   64'(err_pulse),     64'(0));
    check_stats("rst");

    // Unthrottled run, counting source
    cfg_enable = 1'b1;
    cfg_ready_period = '0;
    cfg_ready_on = '0;
    areset = 1'b0;
    src = '0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 1001; i++) begin
      s_axis_tdata = src;
      cycle(hs);
      if (hs) src = src + 1;
      chk("t1_tready", 64'(s_axis_tready), 64'(1));
    end
    s_axis_tvalid = 1'b0;
    chk("t1_beats_1000", 64'(stat_beats),  64'(1000));
    chk("t1_errors_0",   64'(stat_errors), 64'(0));
    chk("t1_locked",     64'(stat_locked), 64'(1));
    check_stats("t1");

    // P=4, N=1 throttle with an always-valid source
    cfg_ready_period = 8'd4;
    cfg_ready_on = 8'd1;
    do_clear();
    src = 32'd500;
    rdy_cnt = 0;
    consec = 0;
    prev_rdy = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s_axis_tdata = src;
      if (s_axis_tready) rdy_cnt++;
      if (s_axis_tready && prev_rdy) consec++;
      prev_rdy = s_axis_tready;
      cycle(hs);
      if (hs) src = src + 1;
    end
    s_axis_tvalid = 1'b0;
    chk("t2_ready_cycles", 64'(rdy_cnt),     64'(100));
    chk("t2_ready_adj",    64'(consec),      64'(0));
    chk("t2_beats_100",    64'(stat_beats),  64'(100));
    chk("t2_errors_0",     64'(stat_errors), 64'(0));
    check_stats("t2");

    // Skip injection 0,1,2,3,4,6,7
    cfg_ready_period = '0;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      send(skip_seq[i]);
      if (i == 5) chk("t3_pulse_after_6", 64'(err_pulse), 64'(1));
      if (i == 6) chk("t3_no_pulse_7",    64'(err_pulse), 64'(0));
    end
    chk("t3_errors_1", 64'(stat_errors),        64'(1));
    chk("t3_fexp_5",   64'(stat_first_err_exp), 64'(5));
    chk("t3_fgot_6",   64'(stat_first_err_got), 64'(6));
    chk("t3_beats_7",  64'(stat_beats),         64'(7));
    check_stats("t3");

    // Modulo wrap of the expected value
    do_clear();
    for (int i = 0; i < 4; i++) send(wrap_seq[i]);
    chk("t4_errors_0", 64'(stat_errors), 64'(0));
    chk("t4_beats_4",  64'(stat_beats),  64'(4));
    check_stats("t4");

    // Clear coincident with a handshake, after an error
    do_clear();
    send(32'd0);
    send(32'd1);
    send(32'd2);
    send(32'd9);
    chk("t5_pre_sticky", 64'(stat_err_sticky), 64'(1));
    s_axis_tdata = 32'd10;
    s_axis_tvalid = 1'b1;
    clear = 1'b1;
    cycle(hs);
    clear = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("t5_clear_hs",     64'(hs),                 64'(1));
    chk("t5_beats_0",      64'(stat_beats),         64'(0));
    chk("t5_errors_0",     64'(stat_errors),        64'(0));
    chk("t5_locked_0",     64'(stat_locked),        64'(0));
    chk("t5_sticky_0",     64'(stat_err_sticky),    64'(0));
    chk("t5_fexp_0",       64'(stat_first_err_exp), 64'(0));
    chk("t5_fgot_0",       64'(stat_first_err_got), 64'(0));
    send(32'd77);
    send(32'd78);
    chk("t5_relock",       64'(stat_locked),        64'(1));
    chk("t5_relock_beats", 64'(stat_beats),         64'(2));
    chk("t5_relock_errs",  64'(stat_errors),        64'(0));
    check_stats("t5");

    // Asynchronous reset between edges, while err_pulse is high
    send(32'd20);
    send(32'd21);
    send(32'd23);
    chk("t6_pulse_before", 64'(err_pulse), 64'(1));
    #2;
    areset = 1'b1;
    #1;
    model_clear();
    chk("t6_tready_0", 64'(s_axis_tready), 64'(0));
    chk("t6_pulse_0",  64'(err_pulse),     64'(0));
    check_stats("t6_async");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    send(32'd50);
    send(32'd51);
    chk("t6_relock",   64'(stat_locked), 64'(1));
    chk("t6_beats_2",  64'(stat_beats),  64'(2));
    chk("t6_errors_0", 64'(stat_errors), 64'(0));
    check_stats("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
